pwm_fader: RTL and testbench
============================

Name: pwm_fader

Overview:
- Upstream feeder for the multi-channel PWM generator. Drives its threshold-write interface (new_thres / sel_thres / set_thres).
- Host/CPU-side logic sets a per-channel target duty and a ramp step. The fader walks each channel's current duty toward its target by at most one step per visit.
- Each changed threshold is presented to the PWM for a guaranteed hold window. This ensures the PWM captures it at its period-overflow point.

Parameters:
- pwm_width, 16, threshold / duty width; must match the downstream PWM.
- num_pwm, 4, channel count; must match the downstream PWM; power of two, >= 2.
- step_width, 8, width of the per-channel ramp step.
- hold_cycles, num_pwm*2**pwm_width, clocks set_thres is held per write; must be >= one full PWM period.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tgt_val  in  pwm_width  target duty for tgt_sel
- tgt_step  in  step_width  ramp step for tgt_sel; 0 = jump directly to target
- tgt_sel  in  $clog2(num_pwm)  channel addressed by a target write
- tgt_wr  in  1  target write strobe, single cycle, always accepted
- new_thres  out  pwm_width  threshold value to the PWM
- sel_thres  out  $clog2(num_pwm)  channel to the PWM
- set_thres  out  1  write strobe to the PWM, held for hold_cycles
- settled  out  num_pwm  bit k = 1 when current[k] == target[k]

Behaviour:
- Reset (async, rst_n low):
  - target[], step[] and current[] all 0.
  - new_thres = 0, sel_thres = 0, set_thres = 0.
  - Channel index ch = 0; FSM in CHECK; hold counter = 0.
  - settled is all ones.
  - Reset asserted mid-HOLD drops set_thres immediately.
- Target write: on any cycle with tgt_wr high, target[tgt_sel] <= tgt_val and step[tgt_sel] <= tgt_step, effective the next cycle. current[] is not modified by a target write.
- FSM states: CHECK, HOLD, NEXT.
- CHECK (1 cycle):
  - If current[ch] == target[ch]: no write; go to NEXT.
  - Otherwise compute nxt:
    - If step[ch] == 0, or |target - current| <= step[ch]: nxt = target.
    - Else if target > current: nxt = current + step.
    - Else: nxt = current - step.
  - Difference is computed in pwm_width+1 bits and step is zero-extended, so no wrap-around is possible; the clamp prevents overshoot.
  - Register current[ch] <= nxt, new_thres <= f(nxt), sel_thres <= ch, set_thres <= 1.
  - Load the hold counter with hold_cycles-1; go to HOLD.
- HOLD:
  - new_thres and sel_thres are stable; set_thres = 1. Counter decrements each cycle.
  - At counter == 0: set_thres <= 0; go to NEXT.
  - set_thres is therefore high for exactly hold_cycles clocks.
- NEXT (1 cycle): ch <= ch + 1, wrapping num_pwm-1 -> 0; go to CHECK.
- A target write to the channel currently in HOLD does not alter the held value. The new target is used on that channel's next CHECK.
- Idle scan (all channels settled) costs 2 cycles per channel; set_thres stays 0.
- f(nxt) = nxt unless the optional feature below is enabled.
- settled is combinational from the registers.

Optional Feature:
- Macro: PWM_FADER_GAMMA_EN.
- Defined: new_thres = (nxt * nxt) >> pwm_width, a square-law perceptual gamma.
  - Full-width 2*pwm_width product; upper pwm_width bits taken.
  - current[] and settled remain linear.
  - Adds one pipeline cycle between CHECK and HOLD (state MUL). set_thres rises one cycle later, with the same hold length.
- Undefined: new_thres = nxt; no multiplier and no MUL state.

Test Plan (bench uses hold_cycles = 8, pwm_width = 16, num_pwm = 4):
1. Reset release with no writes -> set_thres stays 0 for 100 cycles; settled = 4'b1111; new_thres = 0.
2. Write ch2 target 0x0100, step 0 -> one write: sel_thres = 2, new_thres = 0x0100, set_thres high exactly 8 cycles; settled = 4'b1111 afterwards.
3. Write ch1 target 0x0010, step 4 -> four ch1 writes with values 0x0004, 0x0008, 0x000C, 0x0010, one per scan; settled[1] = 0 until the last write issues.
4. Ch1 at 0x0010, write target 0x000E, step 4 -> single write with value 0x000E (clamp; no undershoot to 0x000C).
5. Ch3 target 0xFFFF, step 0xFF, then assert rst_n low mid-HOLD -> set_thres falls asynchronously; after release current[3] = 0 and no write occurs.
6. Ch0 in HOLD at 0x0004 (target 0x0020, step 4), write target 0x0000 during HOLD -> held value stays 0x0004 for the full 8 cycles; next ch0 write is 0x0000.
7. PWM_FADER_GAMMA_EN defined, ch0 target 0x8000, step 0 -> new_thres = 0x4000; set_thres rises one cycle later than the undefined build.

Source files
------------

// File: rtl/pwm_fader_if.sv
// pwm_fader_if: host-side target-write bus plus the threshold-write bus
// that feeds the downstream multi-channel PWM generator.
interface pwm_fader_if #(
  parameter int pwm_width  = 16,
  parameter int num_pwm    = 4,
  parameter int step_width = 8
);
  localparam int SelW = $clog2(num_pwm);

  logic [pwm_width-1:0]  tgt_val;
  logic [step_width-1:0] tgt_step;
  logic [SelW-1:0]       tgt_sel;
  logic                  tgt_wr;
  logic [pwm_width-1:0]  new_thres;
  logic [SelW-1:0]       sel_thres;
  logic                  set_thres;
  logic [num_pwm-1:0]    settled;

  modport master (
    output tgt_val, tgt_step, tgt_sel, tgt_wr,
    input  new_thres, sel_thres, set_thres, settled
  );

  modport slave (
    input  tgt_val, tgt_step, tgt_sel, tgt_wr,
    output new_thres, sel_thres, set_thres, settled
  );
endinterface

// File: rtl/pwm_fader.sv
// pwm_fader: walks each PWM channel's duty toward a host-set target by at
// most one ramp step per scan visit, and presents every changed threshold
// to the PWM for hold_cycles clocks so it is captured at period overflow.
// Optional square-law gamma on the emitted threshold: PWM_FADER_GAMMA_EN.
module pwm_fader #(
  parameter int pwm_width   = 16,
  parameter int num_pwm     = 4,
  parameter int step_width  = 8,
  parameter int hold_cycles = num_pwm * (2 ** pwm_width)
) (
  input  logic       clk,
  input  logic       rst_n,
  pwm_fader_if.slave bus
);

  localparam int SelW  = $clog2(num_pwm);
  localparam int CntW  = $clog2(hold_cycles + 1);
  localparam int DiffW = (pwm_width + 1 > step_width) ? pwm_width + 1 : step_width;
  localparam logic [CntW-1:0] HoldLoad = CntW'(hold_cycles - 1);

`ifdef PWM_FADER_GAMMA_EN
  typedef enum logic [1:0] {CHECK, MUL, HOLD, NEXT} state_t;
`else
  typedef enum logic [1:0] {CHECK, HOLD, NEXT} state_t;
`endif

  state_t                state_q, state_d;
  logic [SelW-1:0]       ch_q, ch_d;
  logic [CntW-1:0]       holdCnt_q, holdCnt_d;
  logic [pwm_width-1:0]  newThres_q, newThres_d;
  logic [SelW-1:0]       selThres_q, selThres_d;
  logic                  setThres_q, setThres_d;
  logic [pwm_width-1:0]  target_q  [num_pwm];
  logic [pwm_width-1:0]  target_d  [num_pwm];
  logic [step_width-1:0] step_q    [num_pwm];
  logic [step_width-1:0] step_d    [num_pwm];
  logic [pwm_width-1:0]  current_q [num_pwm];
  logic [pwm_width-1:0]  current_d [num_pwm];

  logic [pwm_width-1:0]  curCh, tgtCh, nxtVal;
  logic [step_width-1:0] stepCh;
  logic [DiffW-1:0]      absDiff;
  logic                  chMatch;
  logic [num_pwm-1:0]    settledVec;

`ifdef PWM_FADER_GAMMA_EN
  logic [pwm_width-1:0]   nxtPipe_q, nxtPipe_d;
  logic [2*pwm_width-1:0] gammaProd;

  assign gammaProd = {{pwm_width{1'b0}}, nxtPipe_q} * {{pwm_width{1'b0}}, nxtPipe_q};
`endif

  // Ramp one step toward target, clamping to target so a step never overshoots
  always_comb begin
    curCh   = current_q[ch_q];
    tgtCh   = target_q[ch_q];
    stepCh  = step_q[ch_q];
    chMatch = (curCh == tgtCh);
    absDiff = '0;
    nxtVal  = tgtCh;
    if (tgtCh > curCh) begin
      absDiff = DiffW'(tgtCh) - DiffW'(curCh);
    end else begin
      absDiff = DiffW'(curCh) - DiffW'(tgtCh);
    end
    if (stepCh == '0 || absDiff <= DiffW'(stepCh)) begin
      nxtVal = tgtCh;
    end else if (tgtCh > curCh) begin
      nxtVal = pwm_width'(DiffW'(curCh) + DiffW'(stepCh));
    end else begin
      nxtVal = pwm_width'(DiffW'(curCh) - DiffW'(stepCh));
    end
  end

  // Scan FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CHECK;
    end else begin
      state_q <= state_d;
    end
  end

  // Scan FSM next-state: settled channels skip straight to NEXT
  always_comb begin
    state_d = state_q;
    case (state_q)
      CHECK: begin
        if (chMatch) begin
          state_d = NEXT;
        end else begin
`ifdef PWM_FADER_GAMMA_EN
          state_d = MUL;
`else
          state_d = HOLD;
`endif
        end
      end
`ifdef PWM_FADER_GAMMA_EN
      MUL:     state_d = HOLD;
`endif
      HOLD:    state_d = (holdCnt_q == '0) ? NEXT : HOLD;
      NEXT:    state_d = CHECK;
      default: state_d = CHECK;
    endcase
  end

  // Datapath next values: target capture, duty update and threshold presentation
  always_comb begin
    target_d   = target_q;
    step_d     = step_q;
    current_d  = current_q;
    ch_d       = ch_q;
    holdCnt_d  = holdCnt_q;
    newThres_d = newThres_q;
    selThres_d = selThres_q;
    setThres_d = setThres_q;
`ifdef PWM_FADER_GAMMA_EN
    nxtPipe_d  = nxtPipe_q;
`endif
    if (bus.tgt_wr) begin
      target_d[bus.tgt_sel] = bus.tgt_val;
      step_d[bus.tgt_sel]   = bus.tgt_step;
    end
    case (state_q)
      CHECK: begin
        if (!chMatch) begin
          current_d[ch_q] = nxtVal;
`ifdef PWM_FADER_GAMMA_EN
          nxtPipe_d  = nxtVal;
`else
          newThres_d = nxtVal;
          selThres_d = ch_q;
          setThres_d = 1'b1;
          holdCnt_d  = HoldLoad;
`endif
        end
      end
`ifdef PWM_FADER_GAMMA_EN
      MUL: begin
        newThres_d = gammaProd[2*pwm_width-1:pwm_width];
        selThres_d = ch_q;
        setThres_d = 1'b1;
        holdCnt_d  = HoldLoad;
      end
`endif
      HOLD: begin
        if (holdCnt_q == '0) begin
          setThres_d = 1'b0;
        end else begin
          holdCnt_d = holdCnt_q - CntW'(1);
        end
      end
      NEXT:    ch_d = ch_q + SelW'(1);
      default: ;
    endcase
  end

  // Datapath registers; async reset drops set_thres immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q       <= '0;
      holdCnt_q  <= '0;
      newThres_q <= '0;
      selThres_q <= '0;
      setThres_q <= 1'b0;
      for (int k = 0; k < num_pwm; k++) begin
        target_q[k]  <= '0;
        step_q[k]    <= '0;
        current_q[k] <= '0;
      end
`ifdef PWM_FADER_GAMMA_EN
      nxtPipe_q  <= '0;
`endif
    end else begin
      ch_q       <= ch_d;
      holdCnt_q  <= holdCnt_d;
      newThres_q <= newThres_d;
      selThres_q <= selThres_d;
      setThres_q <= setThres_d;
      target_q   <= target_d;
      step_q     <= step_d;
      current_q  <= current_d;
`ifdef PWM_FADER_GAMMA_EN
      nxtPipe_q  <= nxtPipe_d;
`endif
    end
  end

  // Per-channel settled flags straight from the duty registers
  always_comb begin
    settledVec = '0;
    for (int k = 0; k < num_pwm; k++) begin
      settledVec[k] = (current_q[k] == target_q[k]);
    end
  end

  assign bus.new_thres = newThres_q;
  assign bus.sel_thres = selThres_q;
  assign bus.set_thres = setThres_q;
  assign bus.settled   = settledVec;

endmodule

// File: tb/tb_pwm_fader.sv
// tb_pwm_fader: directed stimulus for pwm_fader with a queue scoreboard;
// a monitor pops the expected write on every set_thres rise.
module tb_pwm_fader;

  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] val;
    logic [3:0]  settledExp;
  } wrExp_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  int     testsRun = 0;
  int     testsFailed = 0;
  wrExp_t sb[$];
  wrExp_t curExp;
  logic   curValid = 1'b0;
  logic   inHold = 1'b0;
  int     holdLen = 0;

  pwm_fader_if #(.pwm_width(16), .num_pwm(4), .step_width(8)) bus ();

  pwm_fader #(
    .pwm_width  (16),
    .num_pwm    (4),
    .step_width (8),
    .hold_cycles(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  // Expected emitted threshold for a linear duty value
  function automatic logic [15:0] expVal(input logic [15:0] v);
`ifdef PWM_FADER_GAMMA_EN
    logic [31:0] p;
    p = {16'd0, v} * {16'd0, v};
    return p[31:16];
`else
    return v;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] sel, input logic [15:0] val,
                               input logic [7:0] step);
    @(negedge clk);
    bus.tgt_sel  = sel;
    bus.tgt_val  = val;
    bus.tgt_step = step;
    bus.tgt_wr   = 1'b1;
    @(negedge clk);
    bus.tgt_wr   = 1'b0;
  endtask

  task automatic expectWrite(input logic [1:0] sel, input logic [15:0] val,
                             input logic [3:0] settledExp);
    wrExp_t e;
    e.sel        = sel;
    e.val        = expVal(val);
    e.settledExp = settledExp;
    sb.push_back(e);
  endtask

  task automatic waitIdle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !inHold) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("drainDone", {31'd0, done}, 32'd1);
    repeat (20) @(negedge clk);
  endtask

  task automatic waitRise();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.set_thres) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("riseSeen", {31'd0, seen}, 32'd1);
  endtask

  // Monitor: pop on each set_thres rise, check hold stability and length
  always @(negedge clk) begin
    if (!rst_n) begin
      inHold   = 1'b0;
      curValid = 1'b0;
    end else if (bus.set_thres && !inHold) begin
      inHold  = 1'b1;
      holdLen = 1;
      if (sb.size() == 0) begin
        curValid = 1'b0;
        checkOutput("unexpectedWrite", {30'd0, bus.sel_thres}, 32'hFFFF_FFFF);
      end else begin
        curExp   = sb.pop_front();
        curValid = 1'b1;
        checkOutput("wrSel", {30'd0, bus.sel_thres}, {30'd0, curExp.sel});
        checkOutput("wrVal", {16'd0, bus.new_thres}, {16'd0, curExp.val});
        checkOutput("wrSettled", {28'd0, bus.settled}, {28'd0, curExp.settledExp});
      end
    end else if (bus.set_thres && inHold) begin
      holdLen++;
      if (curValid) begin
        checkOutput("holdVal", {16'd0, bus.new_thres}, {16'd0, curExp.val});
        checkOutput("holdSel", {30'd0, bus.sel_thres}, {30'd0, curExp.sel});
      end
    end else if (!bus.set_thres && inHold) begin
      inHold = 1'b0;
      checkOutput("holdLen", holdLen, 32'd8);
    end
  end

  // Global watchdog so the run always terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence
  initial begin
    int hiCount;
    int lat;
    bus.tgt_wr   = 1'b0;
    bus.tgt_sel  = '0;
    bus.tgt_val  = '0;
    bus.tgt_step = '0;
    rst_n        = 1'b0;

    // Reset state and idle scan
    repeat (3) @(negedge clk);
    checkOutput("rstSetThres", {31'd0, bus.set_thres}, 32'd0);
    checkOutput("rstNewThres", {16'd0, bus.new_thres}, 32'd0);
    checkOutput("rstSelThres", {30'd0, bus.sel_thres}, 32'd0);
    checkOutput("rstSettled", {28'd0, bus.settled}, 32'hF);
    rst_n   = 1'b1;
    hiCount = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.set_thres) hiCount++;
    end
    checkOutput("idleSetThres", hiCount, 32'd0);
    checkOutput("idleSettled", {28'd0, bus.settled}, 32'hF);
    checkOutput("idleNewThres", {16'd0, bus.new_thres}, 32'd0);

    // Jump write (step 0)
    expectWrite(2'd2, 16'h0100, 4'b1111);
    applyStimulus(2'd2, 16'h0100, 8'd0);
    waitIdle();
    checkOutput("jumpSettled", {28'd0, bus.settled}, 32'hF);

    // Ramp up by 4 on ch1
    expectWrite(2'd1, 16'h0004, 4'b1101);
    expectWrite(2'd1, 16'h0008, 4'b1101);
    expectWrite(2'd1, 16'h000C, 4'b1101);
    expectWrite(2'd1, 16'h0010, 4'b1111);
    applyStimulus(2'd1, 16'h0010, 8'd4);
    repeat (2) @(negedge clk);
    checkOutput("rampSettled1", {31'd0, bus.settled[1]}, 32'd0);
    waitIdle();
    checkOutput("rampDoneSettled", {28'd0, bus.settled}, 32'hF);

    // Clamp on downward step
    expectWrite(2'd1, 16'h000E, 4'b1111);
    applyStimulus(2'd1, 16'h000E, 8'd4);
    waitIdle();

    // Reset asserted mid-HOLD
    expectWrite(2'd3, 16'h00FF, 4'b0111);
    applyStimulus(2'd3, 16'hFFFF, 8'hFF);
    waitRise();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncSetThres", {31'd0, bus.set_thres}, 32'd0);
    checkOutput("asyncNewThres", {16'd0, bus.new_thres}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("postRstSettled", {28'd0, bus.settled}, 32'hF);
    checkOutput("postRstNewThres", {16'd0, bus.new_thres}, 32'd0);

    // Target change during HOLD leaves held value alone
    expectWrite(2'd0, 16'h0004, 4'b1110);
    applyStimulus(2'd0, 16'h0020, 8'd4);
    waitRise();
    repeat (2) @(negedge clk);
    expectWrite(2'd0, 16'h0000, 4'b1111);
    applyStimulus(2'd0, 16'h0000, 8'd4);
    waitIdle();

    // Rise latency from a write landing on the first post-reset edge
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    expectWrite(2'd0, 16'h8000, 4'b1111);
    rst_n        = 1'b1;
    bus.tgt_sel  = 2'd0;
    bus.tgt_val  = 16'h8000;
    bus.tgt_step = 8'd0;
    bus.tgt_wr   = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) bus.tgt_wr = 1'b0;
      if (bus.set_thres && lat == 0) lat = k;
    end
`ifdef PWM_FADER_GAMMA_EN
    checkOutput("riseLatency", lat, 32'd10);
`else
    checkOutput("riseLatency", lat, 32'd9);
`endif
    waitIdle();

    checkOutput("pendingWrites", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
